// File: rtl/sram_axi_bridge_if.sv
// rtl/sram_axi_bridge_if.sv - AXI3 single-beat bus bundle between the bridge and the system cache
interface sram_axi_bridge_if #(
    parameter int ID_W = 4
);
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [3:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic [1:0]      arlock;
    logic [3:0]      arcache;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [3:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic [1:0]      awlock;
    logic [3:0]      awcache;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;

    logic [ID_W-1:0] wid;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/sram_axi_bridge.sv
// rtl/sram_axi_bridge.sv - round-robin NUM_CH SRAM-like to single-beat AXI3 bridge
module sram_axi_bridge #(
    parameter int NUM_CH = 2,
    parameter int ID_W   = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [NUM_CH-1:0]     ch_req,
    input  logic [NUM_CH-1:0]     ch_wr,
    input  logic [2*NUM_CH-1:0]   ch_size,
    input  logic [32*NUM_CH-1:0]  ch_addr,
    input  logic [32*NUM_CH-1:0]  ch_wdata,
    output logic [NUM_CH-1:0]     ch_addr_ok,
    output logic [NUM_CH-1:0]     ch_data_ok,
    output logic [31:0]           ch_rdata,
    output logic                  ch_err,
    sram_axi_bridge_if.master     axi
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_W, S_B} state_t;

    state_t          state;
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] cur_ch;
    logic [31:0]     cur_addr;
    logic [31:0]     cur_wdata;
    logic [1:0]      cur_size;
    logic            arvalid_r, rready_r, awvalid_r, wvalid_r, bready_r;

    logic [CH_W-1:0] gnt_idx;
    logic            gnt_valid;
    logic [CH_W:0]   scan_idx;
    logic [3:0]      wstrb_c;

    logic [31:0] addr_a  [NUM_CH];
    logic [31:0] wdata_a [NUM_CH];
    logic [1:0]  size_a  [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign addr_a[i]  = ch_addr[32*i +: 32];
        assign wdata_a[i] = ch_wdata[32*i +: 32];
        assign size_a[i]  = ch_size[2*i +: 2];
    end

    // Round-robin search: first requester at or after rr_ptr, wrapping at NUM_CH
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            scan_idx = {1'b0, rr_ptr} + (CH_W+1)'(k);
            if (scan_idx >= (CH_W+1)'(NUM_CH)) begin
                scan_idx = scan_idx - (CH_W+1)'(NUM_CH);
            end
            if (!gnt_valid && ch_req[scan_idx[CH_W-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = scan_idx[CH_W-1:0];
            end
        end
    end

    // Acceptance is combinational so a requester sees addr_ok in its request cycle
    always_comb begin
        ch_addr_ok = '0;
        if (state == S_IDLE && gnt_valid) begin
            ch_addr_ok[gnt_idx] = 1'b1;
        end
    end

    // Byte-lane strobes from the latched size and low address bits
    always_comb begin
        case (cur_size)
            2'd0:    wstrb_c = 4'b0001 << cur_addr[1:0];
            2'd1:    wstrb_c = 4'b0011 << cur_addr[1:0];
            default: wstrb_c = 4'b1111;
        endcase
    end

    // Transaction FSM: one outstanding AXI transaction, registered handshake outputs
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            cur_ch     <= '0;
            cur_addr   <= '0;
            cur_wdata  <= '0;
            cur_size   <= '0;
            arvalid_r  <= 1'b0;
            rready_r   <= 1'b0;
            awvalid_r  <= 1'b0;
            wvalid_r   <= 1'b0;
            bready_r   <= 1'b0;
            ch_data_ok <= '0;
            ch_err     <= 1'b0;
            ch_rdata   <= '0;
        end else begin
            ch_data_ok <= '0;
            case (state)
                S_IDLE: begin
                    if (gnt_valid) begin
                        cur_ch    <= gnt_idx;
                        cur_addr  <= addr_a[gnt_idx];
                        cur_wdata <= wdata_a[gnt_idx];
                        cur_size  <= size_a[gnt_idx];
                        rr_ptr    <= (gnt_idx == CH_W'(NUM_CH-1)) ? '0 : gnt_idx + CH_W'(1);
                        if (ch_wr[gnt_idx]) begin
                            state     <= S_W;
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                        end else begin
                            state     <= S_AR;
                            arvalid_r <= 1'b1;
                        end
                    end
                end
                S_AR: begin
                    if (axi.arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state     <= S_R;
                    end
                end
                S_R: begin
                    if (axi.rvalid) begin
                        rready_r   <= 1'b0;
                        ch_rdata   <= axi.rdata;
                        ch_err     <= |axi.rresp;
                        ch_data_ok <= NUM_CH'(1) << cur_ch;
                        state      <= S_IDLE;
                    end
                end
                S_W: begin
                    if (axi.awready) awvalid_r <= 1'b0;
                    if (axi.wready)  wvalid_r  <= 1'b0;
                    if ((!awvalid_r || axi.awready) && (!wvalid_r || axi.wready)) begin
                        bready_r <= 1'b1;
                        state    <= S_B;
                    end
                end
                S_B: begin
                    if (axi.bvalid) begin
                        bready_r   <= 1'b0;
                        ch_err     <= |axi.bresp;
                        ch_data_ok <= NUM_CH'(1) << cur_ch;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign axi.arid    = ID_W'(cur_ch);
    assign axi.araddr  = cur_addr;
    assign axi.arlen   = 4'd0;
    assign axi.arsize  = {1'b0, cur_size};
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'd0;
    assign axi.arprot  = 3'd0;
    assign axi.arvalid = arvalid_r;
    assign axi.rready  = rready_r;

    assign axi.awid    = ID_W'(cur_ch);
    assign axi.awaddr  = cur_addr;
    assign axi.awlen   = 4'd0;
    assign axi.awsize  = {1'b0, cur_size};
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'd0;
    assign axi.awprot  = 3'd0;
    assign axi.awvalid = awvalid_r;

    assign axi.wid     = ID_W'(cur_ch);
    assign axi.wdata   = cur_wdata;
    assign axi.wstrb   = wstrb_c;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = wvalid_r;
    assign axi.bready  = bready_r;

    // Response IDs and rlast are not needed with a single outstanding single-beat transaction
    logic unused_ok;
    assign unused_ok = &{1'b0, axi.rid, axi.rlast, axi.bid};
endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb/tb_sram_axi_bridge.sv - self-checking bench for sram_axi_bridge
module tb_sram_axi_bridge;
    localparam int NCH = 3;
    localparam int IDW = 4;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    logic [NCH-1:0]    ch_req, ch_wr, ch_addr_ok, ch_data_ok;
    logic [2*NCH-1:0]  ch_size;
    logic [32*NCH-1:0] ch_addr, ch_wdata;
    logic [31:0]       ch_rdata;
    logic              ch_err;

    sram_axi_bridge_if #(.ID_W(IDW)) axi ();

    sram_axi_bridge #(.NUM_CH(NCH), .ID_W(IDW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok), .ch_rdata(ch_rdata), .ch_err(ch_err),
        .axi(axi)
    );

    typedef struct { bit wr; bit [1:0] size; bit [31:0] addr; bit [31:0] wdata; } req_t;
    typedef struct {
        int ch; bit wr; bit [1:0] size; bit [31:0] addr; bit [31:0] wdata; bit [31:0] rdata; bit [1:0] resp;
        bit [2:0] x_size; bit [3:0] x_strb; bit [31:0] x_rdata; bit x_err;
    } vec_t;

    req_t rq [NCH][$];
    int checks = 0;
    int errors = 0;

    int cyc = 0, rr_m = 0, cur_ch = 0, t_acc = 0, t_aw = 0, t_w = 0, t_dok = 0, dok_cnt = 0;
    int r_dly = 0, b_dly = 0;
    bit busy, ar_done, aw_done, w_done, resp_done, r_pend, b_pend, dok_exp, err_exp;
    bit acc [NCH];
    req_t cur;
    logic [31:0] rdata_exp;
    bit [31:0] mem [int];
    int gnt_log [$];

    int p_rdy = 100, max_dly = 0, err_pct = 0, aw_wait = 0, w_wait = 0;
    bit force_on = 0;
    bit [31:0] f_rdata;
    bit [1:0] f_resp;

    logic [2:0] cap_size;
    logic [IDW-1:0] cap_id;
    logic [3:0] cap_strb;
    logic [NCH-1:0] cap_dok;
    logic [31:0] cap_rdata;
    logic cap_err;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] strobe_of(input bit [1:0] size, input bit [31:0] addr);
        int lo = int'(addr[1:0]);
        int nb = 1 << size;
        logic [3:0] s = '0;
        for (int b = 0; b < 4; b++) if (b >= lo && b < lo + nb) s[b] = 1'b1;
        return s;
    endfunction

    function automatic int pick(input logic [NCH-1:0] req, input int ptr);
        for (int k = 0; k < NCH; k++) if (req[(ptr + k) % NCH]) return (ptr + k) % NCH;
        return -1;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < NCH; i++) if (rq[i].size() > 0) return 1'b1;
        return busy;
    endfunction

    function automatic bit [1:0] pick_resp();
        if (force_on) return f_resp;
        return ($urandom_range(99) < err_pct) ? 2'($urandom_range(3, 2)) : 2'b00;
    endfunction

    task automatic model_clear();
        busy = 0; rr_m = 0; ar_done = 0; aw_done = 0; w_done = 0; resp_done = 0;
        r_pend = 0; b_pend = 0; dok_exp = 0; err_exp = 0; rdata_exp = '0;
        for (int i = 0; i < NCH; i++) begin rq[i].delete(); acc[i] = 0; end
        gnt_log.delete();
        ch_req = '0; ch_wr = '0; ch_size = '0; ch_addr = '0; ch_wdata = '0;
        axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = '0; axi.rid = '0; axi.rlast = 1'b1;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = '0; axi.bid = '0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        model_clear();
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NCH; i++) begin
            if (acc[i]) begin void'(rq[i].pop_front()); acc[i] = 0; end
            if (rq[i].size() > 0) begin
                ch_req[i] = 1'b1;
                ch_wr[i] = rq[i][0].wr;
                ch_size[2*i +: 2] = rq[i][0].size;
                ch_addr[32*i +: 32] = rq[i][0].addr;
                ch_wdata[32*i +: 32] = rq[i][0].wdata;
            end else begin
                ch_req[i] = 1'b0;
            end
        end
        axi.arready = ($urandom_range(99) < p_rdy);
        axi.awready = ((cyc - t_acc) > aw_wait) && ($urandom_range(99) < p_rdy);
        axi.wready  = ((cyc - t_acc) > w_wait) && ($urandom_range(99) < p_rdy);
        if (r_pend && r_dly == 0) axi.rvalid = 1'b1;
        else begin axi.rvalid = 1'b0; if (r_pend) r_dly--; end
        if (b_pend && b_dly == 0) axi.bvalid = 1'b1;
        else begin axi.bvalid = 1'b0; if (b_pend) b_dly--; end
    endtask

    task automatic sample();
        logic [NCH-1:0] e;
        int g;
        bit in_w;
        int wa;
        chk("rready", axi.rready, r_pend);
        chk("bready", axi.bready, b_pend);
        e = dok_exp ? (NCH'(1) << cur_ch) : '0;
        chk("data_ok", ch_data_ok, e);
        if (dok_exp) begin
            chk("rdata", ch_rdata, rdata_exp);
            chk("err", ch_err, err_exp);
            cap_dok = ch_data_ok; cap_rdata = ch_rdata; cap_err = ch_err;
            t_dok = cyc; dok_cnt++; busy = 0; dok_exp = 0;
        end
        g = busy ? -1 : pick(ch_req, rr_m);
        e = (g >= 0) ? (NCH'(1) << g) : '0;
        chk("addr_ok", ch_addr_ok, e);
        if (g >= 0) begin
            gnt_log.push_back(g);
            rr_m = (g + 1) % NCH; busy = 1; cur = rq[g][0]; cur_ch = g; acc[g] = 1; t_acc = cyc;
            ar_done = 0; aw_done = 0; w_done = 0; resp_done = 0;
        end
        if (axi.rvalid && axi.rready) begin
            r_pend = 0; dok_exp = 1; rdata_exp = axi.rdata; err_exp = |axi.rresp;
        end
        if (axi.bvalid && axi.bready) begin
            b_pend = 0; resp_done = 1; dok_exp = 1; err_exp = |axi.bresp;
        end
        chk("arvalid", axi.arvalid, busy && !cur.wr && !ar_done && cyc > t_acc);
        if (axi.arvalid && busy && !cur.wr && !ar_done && cyc > t_acc) begin
            chk("ar_fields", {axi.araddr, axi.arsize, axi.arid, axi.arlen, axi.arburst, axi.arlock, axi.arcache, axi.arprot},
                {cur.addr, 1'b0, cur.size, IDW'(cur_ch), 4'd0, 2'b01, 2'b00, 4'd0, 3'd0});
            if (axi.arready) begin
                ar_done = 1; r_pend = 1; r_dly = $urandom_range(max_dly, 0);
                cap_size = axi.arsize; cap_id = axi.arid;
                wa = int'(cur.addr[31:2]);
                if (force_on) axi.rdata = f_rdata;
                else axi.rdata = mem.exists(wa) ? mem[wa] : $urandom;
                axi.rresp = pick_resp();
            end
        end
        in_w = busy && cur.wr && cyc > t_acc;
        chk("awvalid", axi.awvalid, in_w && !aw_done);
        if (axi.awvalid && in_w && !aw_done) begin
            chk("aw_fields", {axi.awaddr, axi.awsize, axi.awid, axi.awlen, axi.awburst, axi.awlock, axi.awcache, axi.awprot},
                {cur.addr, 1'b0, cur.size, IDW'(cur_ch), 4'd0, 2'b01, 2'b00, 4'd0, 3'd0});
            if (axi.awready) begin
                aw_done = 1; t_aw = cyc; cap_size = axi.awsize; cap_id = axi.awid;
            end
        end
        chk("wvalid", axi.wvalid, in_w && !w_done);
        if (axi.wvalid && in_w && !w_done) begin
            chk("w_fields", {axi.wdata, axi.wstrb, axi.wlast, axi.wid},
                {cur.wdata, strobe_of(cur.size, cur.addr), 1'b1, IDW'(cur_ch)});
            if (axi.wready) begin
                w_done = 1; t_w = cyc; cap_strb = axi.wstrb;
                wa = int'(cur.addr[31:2]);
                if (!mem.exists(wa)) mem[wa] = '0;
                for (int b = 0; b < 4; b++) if (axi.wstrb[b]) mem[wa][8*b +: 8] = axi.wdata[8*b +: 8];
            end
        end
        if (in_w && aw_done && w_done && !b_pend && !resp_done) begin
            b_pend = 1; b_dly = $urandom_range(max_dly, 0); axi.bresp = pick_resp();
        end
    endtask

    task automatic step();
        @(negedge aclk);
        cyc++;
        drive_inputs();
        #1;
        sample();
    endtask

    task automatic run_idle(input int bound);
        int n = 0;
        while (pending() && n < bound) begin step(); n++; end
        chk("drain_in_time", n < bound, 1'b1);
        step();
    endtask

    task automatic push(input int ch, input bit wr, input bit [1:0] size, input bit [31:0] addr, input bit [31:0] wdata);
        req_t r;
        r.wr = wr; r.size = size; r.addr = addr; r.wdata = wdata;
        rq[ch].push_back(r);
    endtask

    vec_t vt [7];
    int d0, nr;

    initial begin
        vt[0] = '{0, 1'b0, 2'd2, 32'hBFC00000, 32'h0,        32'h3C08BFAF, 2'd0, 3'd2, 4'hF,    32'h3C08BFAF, 1'b0};
        vt[1] = '{1, 1'b1, 2'd1, 32'h80001002, 32'hBEEF0000, 32'h0,        2'd0, 3'd1, 4'b1100, 32'h3C08BFAF, 1'b0};
        vt[2] = '{2, 1'b1, 2'd0, 32'h00000003, 32'h11000000, 32'h0,        2'd0, 3'd0, 4'b1000, 32'h3C08BFAF, 1'b0};
        vt[3] = '{0, 1'b0, 2'd2, 32'h00001000, 32'h0,        32'hDEADBEEF, 2'd2, 3'd2, 4'hF,    32'hDEADBEEF, 1'b1};
        vt[4] = '{1, 1'b0, 2'd1, 32'h00002002, 32'h0,        32'h12345678, 2'd0, 3'd1, 4'hF,    32'h12345678, 1'b0};
        vt[5] = '{2, 1'b1, 2'd2, 32'h00003000, 32'hA5A5A5A5, 32'h0,        2'd3, 3'd2, 4'b1111, 32'h12345678, 1'b1};
        vt[6] = '{0, 1'b1, 2'd0, 32'h00003001, 32'h0000C300, 32'h0,        2'd0, 3'd0, 4'b0010, 32'h12345678, 1'b0};

        aresetn = 1'b0;
        model_clear();
        #1;
        chk("reset_outputs", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready, ch_data_ok, ch_err, ch_rdata}, '0);
        do_reset();

        force_on = 1;
        for (int i = 0; i < 7; i++) begin
            f_rdata = vt[i].rdata; f_resp = vt[i].resp;
            push(vt[i].ch, vt[i].wr, vt[i].size, vt[i].addr, vt[i].wdata);
            run_idle(50);
            chk("vec_latency", t_dok - t_acc, 3);
            chk("vec_data_ok", cap_dok, NCH'(1) << vt[i].ch);
            chk("vec_size", cap_size, vt[i].x_size);
            chk("vec_id", cap_id, IDW'(vt[i].ch));
            if (vt[i].wr) chk("vec_wstrb", cap_strb, vt[i].x_strb);
            chk("vec_rdata", cap_rdata, vt[i].x_rdata);
            chk("vec_err", cap_err, vt[i].x_err);
        end
        force_on = 0;

        d0 = dok_cnt; w_wait = 2;
        push(1, 1'b1, 2'd1, 32'h80001002, 32'hBEEF0000);
        run_idle(50);
        chk("aw_before_w_gap", t_w - t_aw, 2);
        chk("aw_before_w_strb", cap_strb, 4'b1100);
        chk("aw_before_w_once", dok_cnt - d0, 1);
        w_wait = 0; aw_wait = 3;
        push(2, 1'b1, 2'd2, 32'h00004000, 32'hCAFEF00D);
        run_idle(50);
        chk("w_before_aw_gap", t_aw - t_w, 3);
        aw_wait = 0;

        do_reset();
        p_rdy = 70; max_dly = 2;
        for (int k = 0; k < 6; k++) begin
            push(0, 1'b0, 2'd2, 32'h100 + 32'(4*k), 0);
            push(1, 1'b0, 2'd2, 32'h200 + 32'(4*k), 0);
        end
        run_idle(2000);
        chk("rr01_count", gnt_log.size(), 12);
        for (int k = 0; k < gnt_log.size(); k++) chk("rr01_order", gnt_log[k], k % 2);

        do_reset();
        for (int k = 0; k < 6; k++) begin
            push(0, 1'b1, 2'd2, 32'h300 + 32'(4*k), $urandom);
            push(2, 1'b0, 2'd2, 32'h300 + 32'(4*k), 0);
        end
        run_idle(2000);
        chk("rr02_count", gnt_log.size(), 12);
        for (int k = 0; k < gnt_log.size(); k++) chk("rr02_order", gnt_log[k], (k % 2) * 2);

        p_rdy = 100; max_dly = 0; aw_wait = 100; w_wait = 100;
        push(0, 1'b1, 2'd2, 32'h00005000, 32'h01020304);
        repeat (5) step();
        chk("w_stalled_awvalid", axi.awvalid, 1'b1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("rst_async_awvalid", axi.awvalid, 1'b0);
        chk("rst_async_wvalid", axi.wvalid, 1'b0);
        chk("rst_async_data_ok", ch_data_ok, '0);
        model_clear();
        aw_wait = 0; w_wait = 0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        d0 = dok_cnt; force_on = 1; f_rdata = 32'h0BADCAFE; f_resp = 2'd0;
        push(1, 1'b0, 2'd2, 32'h00006000, 0);
        run_idle(50);
        force_on = 0;
        chk("post_rst_read_once", dok_cnt - d0, 1);
        chk("post_rst_data_ok", cap_dok, 3'b010);
        chk("post_rst_rdata", cap_rdata, 32'h0BADCAFE);

        p_rdy = 60; max_dly = 3; err_pct = 15;
        d0 = dok_cnt; nr = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NCH; i++) begin
                if (rq[i].size() == 0 && $urandom_range(99) < 30) begin
                    bit [1:0] sz = 2'($urandom_range(2, 0));
                    bit [31:0] ad = {20'h0, 12'($urandom)} & ~((32'd1 << sz) - 32'd1);
                    push(i, 1'($urandom), sz, ad, $urandom);
                    nr++;
                end
            end
            step();
        end
        run_idle(500);
        chk("random_completions", dok_cnt - d0, nr);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
Parametrised successor to the two-channel SRAM-like-to-AXI bridge that sits between the mips core and the system cache.
- Accepts NUM_CH SRAM-like request channels (inst, data, and later extra requesters such as a TLB refill walker or DMA).
- Arbitrates round-robin among them and issues one single-beat AXI3 transaction at a time.
- Returns the response with a per-channel data_ok and an error flag.

Parameters:
NUM_CH, 2, number of SRAM-like request channels; channel i uses slice i of every ch_* vector.
ID_W, 4, AXI ID width; arid/awid carry the granted channel index, zero-extended.

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
ch_req  in  NUM_CH  per-channel request valid
ch_wr  in  NUM_CH  1 = write, 0 = read
ch_size  in  2*NUM_CH  per-channel size: 0 = byte, 1 = half, 2 = word
ch_addr  in  32*NUM_CH  per-channel byte address
ch_wdata  in  32*NUM_CH  per-channel write data, lane-aligned to the address
ch_addr_ok  out  NUM_CH  request accepted (one-hot or zero)
ch_data_ok  out  NUM_CH  response done (one-cycle pulse)
ch_rdata  out  32  read data, shared by all channels, valid while data_ok is high and held afterwards
ch_err  out  1  high together with data_ok when rresp or bresp != 0
arid/araddr/arlen[3:0]/arsize[2:0]/arburst[1:0]/arlock[1:0]/arcache[3:0]/arprot[2:0]/arvalid  out; arready  in  AXI3 read address channel
rid/rdata/rresp/rlast/rvalid  in; rready  out  AXI3 read data channel
awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out; awready  in  AXI3 write address channel
wid/wdata/wstrb/wlast/wvalid  out; wready  in  AXI3 write data channel
bid/bresp/bvalid  in; bready  out  AXI3 write response channel

Behaviour:
- State machine: IDLE, AR, R, W (AW+W), B. Only one transaction is outstanding at any time.
- Reset (asynchronous, aresetn low), effective immediately:
  - state = IDLE, rr pointer = 0.
  - All valid/ready outputs = 0; ch_data_ok = 0, ch_err = 0, ch_rdata = 0.
  - Any in-flight AXI transaction is abandoned.
- IDLE:
  - Grant g = the first requesting channel at or after rr pointer, wrapping at NUM_CH.
  - ch_addr_ok[g] is asserted combinationally in the same cycle as ch_req[g]; no other addr_ok bit is high.
  - On acceptance, latch addr, size, wdata, wr and g. Set rr pointer = (g+1) mod NUM_CH.
  - Next state: W if wr, else AR.
- AR:
  - arvalid = 1 with the latched fields, held stable until arready; then go to R.
  - araddr = latched address, unaligned bits kept; arsize = {0,size}.
- R:
  - rready = 1. rid is not checked.
  - On rvalid&&rready: register rdata into ch_rdata, register ch_err = |rresp, go to IDLE.
  - The next cycle pulses ch_data_ok[g] for exactly one cycle.
- W:
  - awvalid and wvalid are both asserted on entry.
  - Each is dropped independently after its own handshake; the two handshakes may occur in the same or in different cycles, in either order.
  - When both are complete, go to B.
  - wlast = 1, wid = awid.
  - wstrb: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
- B:
  - bready = 1.
  - On bvalid: register ch_err = |bresp, go to IDLE; ch_data_ok[g] pulses the following cycle.
- Constant fields:
  - arlen = awlen = 0, arburst = awburst = 2'b01 (INCR).
  - arlock = awlock = 0, arcache = awcache = 0, arprot = awprot = 0.
  - arid = awid = g.
- Data-phase requests: a request arriving while not IDLE is not acknowledged. The requester holds ch_req and its fields stable until addr_ok.
- Back-to-back: the data_ok pulse cycle is already IDLE, so a new addr_ok can coincide with data_ok. Minimum read turnaround is addr_ok to data_ok = 3 cycles with zero-wait AXI.
- Simultaneous requests from all channels are served in rr order; no channel waits more than NUM_CH-1 transactions.
- ch_size = 3 is illegal and its behaviour is unspecified; the bench must not drive it.

Test Plan:
- Read on ch0, addr 0xBFC00000 word, arready/rvalid immediate, rdata 0x3C08BFAF → arvalid cycle 1, araddr 0xBFC00000, arsize 2, arid 0; ch_data_ok = 01 in cycle 3; ch_rdata = 0x3C08BFAF; ch_err = 0.
- Write on ch1, half at 0x80001002, wdata 0xBEEF0000, awready 2 cycles before wready → awvalid drops first; wstrb = 1100, awsize 1, awid 1; single ch_data_ok = 10 pulse after bvalid.
- ch0 and ch1 request together continuously, NUM_CH=2 → grants alternate 0,1,0,1; addr_ok is never high on both channels in the same cycle.
- NUM_CH=3: ch0 and ch2 request continuously, ch1 idle → rr skips ch1; grant order 0,2,0,2.
- Read returns rresp = 2'b10 (SLVERR) → ch_err = 1 coincident with ch_data_ok; the next transaction with OKAY gives ch_err = 0.
- aresetn low while in W with awvalid = 1 and awready low → awvalid and wvalid = 0 immediately and state = IDLE; after release, a new read is accepted normally and no stale data_ok is produced.
